md_sched: RTL and testbench

- Sequencing controller for the shared multiply/divide (HI/LO) unit of the pipelined CPU. Sits beside the E-stage md datapath.
- Decodes the E-stage md operation and decides when to issue it. Times the fixed multiply/divide latency and emits the HI/LO commit strobe.
- Generates the D-stage stall for md-class instructions. Blocks new issues during an exception/interrupt request (req).
- Holds no arithmetic; the datapath latches operands on issue_start and writes HI/LO on commit.

---
 rtl/md_sched.sv | 136 +++++++++++++
 tb/tb_md_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: issue/commit sequencer for the shared HI/LO multiply-divide unit.
// Ports:
//   clk, reset (async, active-low)
//   req          exception/interrupt request; blocks new issues and moves
//   op_valid     E-stage holds an md operation
//   op_type      encoded md operation (see decode below)
//   d_is_md      D-stage instruction is md-class
//   issue_start  datapath latches operands / starts computing this cycle
//   issue_kind   0 none, 1 mul-class, 2 div-class, 3 move
//   wr_hi/wr_lo  direct HI/LO write strobes for mthi/mtlo
//   commit       datapath copies temp result into HI/LO this cycle
//   busy         an operation is in flight
//   stall        freeze the D stage
//   ovr_err      sticky protocol-violation flag
module md_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       op_valid,
    input  logic [3:0] op_type,
    input  logic       d_is_md,
    output logic       issue_start,
    output logic [1:0] issue_kind,
    output logic       wr_hi,
    output logic       wr_lo,
    output logic       commit,
    output logic       busy,
    output logic       stall,
    output logic       ovr_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // The counter is loaded with LAT-2: one cycle is spent in the issue
    // cycle itself and one in COMMIT, the rest are counted down in RUN.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 2);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 2);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_commit;
    logic       r_busy;
    logic       r_ovr;

    logic w_mul;
    logic w_div;
    logic w_mv;
    logic w_start;
    logic w_idle;
    logic w_gate;
    logic w_accept;
    logic w_move;
    logic w_viol;

    always_comb begin
        w_mul = 1'b0;
        w_div = 1'b0;
        w_mv  = 1'b0;
        case (op_type)
            4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12: w_mul = 1'b1;
            4'd3, 4'd4:                           w_div = 1'b1;
            4'd5, 4'd6:                           w_mv  = 1'b1;
            default: ;
        endcase
    end

    assign w_start  = w_mul | w_div;
    assign w_idle   = (r_state == S_IDLE);
    assign w_gate   = w_idle & op_valid & ~req;
    assign w_accept = w_gate & w_start;
    assign w_move   = w_gate & w_mv;

    // Any start or move presented while an operation is in flight is
    // dropped and flagged; req does not excuse it.
    assign w_viol = ~w_idle & op_valid & (w_start | w_mv);

    assign issue_start = w_accept;
    assign issue_kind  = w_accept ? (w_div ? 2'd2 : 2'd1)
                       : w_move   ? 2'd3
                       : 2'd0;
    assign wr_hi   = w_move & (op_type == 4'd5);
    assign wr_lo   = w_move & (op_type == 4'd6);
    assign commit  = r_commit;
    assign busy    = r_busy;
    assign stall   = d_is_md & (r_busy | w_accept);
    assign ovr_err = r_ovr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_commit <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_cnt   <= w_div ? DIV_CNT : MUL_CNT;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_COMMIT;
                        r_commit <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_COMMIT: begin
                    r_state  <= S_IDLE;
                    r_commit <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_commit <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
            if (w_viol) begin
                r_ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scoreboard bench for md_sched.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and checks.
module tb_md_sched;

    logic       clk = 1'b1;
    logic       reset;
    logic       req;
    logic       op_valid;
    logic [3:0] op_type;
    logic       d_is_md;
    logic       issue_start;
    logic [1:0] issue_kind;
    logic       wr_hi;
    logic       wr_lo;
    logic       commit;
    logic       busy;
    logic       stall;
    logic       ovr_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8:0] exp;
        logic [8:0] mask;
        string      name;
    } item_t;

    item_t q[$];

    localparam logic [8:0] ALL = 9'h1FF;
    localparam logic [8:0] REG = 9'h00D;

    md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .op_valid(op_valid),
        .op_type(op_type),
        .d_is_md(d_is_md),
        .issue_start(issue_start),
        .issue_kind(issue_kind),
        .wr_hi(wr_hi),
        .wr_lo(wr_lo),
        .commit(commit),
        .busy(busy),
        .stall(stall),
        .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    // Packing: {issue_start, issue_kind, wr_hi, wr_lo, commit, busy, stall, ovr_err}
    function automatic logic [8:0] E(input logic is, input logic [1:0] k,
                                     input logic wh, input logic wl,
                                     input logic cm, input logic bz,
                                     input logic st, input logic ov);
        return {is, k, wh, wl, cm, bz, st, ov};
    endfunction

    task automatic step(input logic rst, input logic rq, input logic v,
                        input logic [3:0] ty, input logic dm,
                        input logic [8:0] exp, input logic [8:0] mask,
                        input string name);
        item_t it;
        reset    = rst;
        req      = rq;
        op_valid = v;
        op_type  = ty;
        d_is_md  = dm;
        it.exp   = exp;
        it.mask  = mask;
        it.name  = name;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [8:0] act;
            it  = q.pop_front();
            act = {issue_start, issue_kind, wr_hi, wr_lo,
                   commit, busy, stall, ovr_err};
            total++;
            if ((act & it.mask) !== (it.exp & it.mask)) begin
                bad++;
                $display("FAIL %s: got %b want %b (mask %b)",
                         it.name, act, it.exp, it.mask);
            end
        end
    end

    initial begin
        // reset held, mult presented: registered outputs must be clear
        step(0, 0, 1, 4'd1, 0, E(0,0,0,0,0,0,0,0), REG, "rst_regs");
        step(0, 0, 0, 4'd0, 0, E(0,0,0,0,0,0,0,0), ALL, "rst_idle");

        // mult: issue t, busy t+1..t+5, commit t+5
        step(1, 0, 1, 4'd1, 0, E(1,1,0,0,0,0,0,0), ALL, "mul_issue");
        for (int i = 1; i <= 4; i++)
            step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "mul_busy");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,1,1,0,0), ALL, "mul_commit");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,0,0,0), ALL, "mul_done");

        // div with D-stage md op: stall t..t+10, commit t+10
        step(1, 0, 1, 4'd3, 1, E(1,2,0,0,0,0,1,0), ALL, "div_issue");
        for (int i = 1; i <= 9; i++)
            step(1, 0, 0, 4'd0, 1, E(0,0,0,0,0,1,1,0), ALL, "div_busy");
        step(1, 0, 0, 4'd0, 1, E(0,0,0,0,1,1,1,0), ALL, "div_commit");
        step(1, 0, 0, 4'd0, 1, E(0,0,0,0,0,0,0,0), ALL, "div_nostall");

        // req blocks an IDLE issue
        step(1, 1, 1, 4'd1, 0, E(0,0,0,0,0,0,0,0), ALL, "req_block");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,0,0,0), ALL, "req_stay_idle");

        // req during an in-flight mult does not disturb it
        step(1, 0, 1, 4'd1, 0, E(1,1,0,0,0,0,0,0), ALL, "reqrun_issue");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "reqrun_b1");
        step(1, 1, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "reqrun_b2");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "reqrun_b3");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "reqrun_b4");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,1,1,0,0), ALL, "reqrun_commit");
        // back-to-back: new issue in the first IDLE cycle after commit
        step(1, 0, 1, 4'd10, 0, E(1,1,0,0,0,0,0,0), ALL, "b2b_issue");
        for (int i = 1; i <= 4; i++)
            step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "b2b_busy");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,1,1,0,0), ALL, "b2b_commit");

        // moves and non-issuing types in IDLE
        step(1, 0, 1, 4'd5, 0, E(0,3,1,0,0,0,0,0), ALL, "mthi");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,0,0,0), ALL, "mthi_nobusy");
        step(1, 1, 1, 4'd6, 0, E(0,0,0,0,0,0,0,0), ALL, "mtlo_req");
        step(1, 0, 1, 4'd6, 0, E(0,3,0,1,0,0,0,0), ALL, "mtlo");
        step(1, 0, 1, 4'd7, 1, E(0,0,0,0,0,0,0,0), ALL, "mfhi_idle");
        step(1, 0, 1, 4'd14, 0, E(0,0,0,0,0,0,0,0), ALL, "type14");

        // violation: divu injected during multu
        step(1, 0, 1, 4'd2, 0, E(1,1,0,0,0,0,0,0), ALL, "ovr_issue");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "ovr_b1");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "ovr_b2");
        step(1, 0, 1, 4'd4, 0, E(0,0,0,0,0,1,0,0), ALL, "ovr_inject");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,1), ALL, "ovr_set");
        // commit with mfhi in D: stall while busy, drops next cycle
        step(1, 0, 0, 4'd0, 1, E(0,0,0,0,1,1,1,1), ALL, "ovr_commit");
        step(1, 0, 0, 4'd0, 1, E(0,0,0,0,0,0,0,1), ALL, "ovr_hold");

        // reset in the middle of a div clears everything at once
        step(1, 0, 1, 4'd3, 0, E(1,2,0,0,0,0,0,1), ALL, "rdiv_issue");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,1), ALL, "rdiv_b1");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,1), ALL, "rdiv_b2");
        step(0, 0, 0, 4'd0, 0, E(0,0,0,0,0,0,0,0), ALL, "rdiv_reset");

        // madd right after release: normal 5-cycle sequence
        step(1, 0, 1, 4'd9, 0, E(1,1,0,0,0,0,0,0), ALL, "madd_issue");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,0), ALL, "madd_b1");
        // mtlo while busy: no strobe, flags violation
        step(1, 0, 1, 4'd6, 0, E(0,0,0,0,0,1,0,0), ALL, "mv_busy");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,1), ALL, "mv_ovr_b3");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,1,0,1), ALL, "mv_ovr_b4");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,1,1,0,1), ALL, "madd_commit");
        step(1, 0, 0, 4'd0, 0, E(0,0,0,0,0,0,0,1), ALL, "madd_done");

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
